// File: rtl/decode_64b67b_gearbox_sync.sv
// ---------------------------------------------------------------------------
// decode_64b67b_gearbox_sync
//
// Receive-side 64B/67B (Interlaken) decoder. A bit-accurate gearbox collects
// DATA_W-bit receive words and cuts 67-bit blocks out of the bit stream. A
// block-lock FSM watches the sync headers and slips the gearbox by one bit
// on every bad header until it finds alignment. Once aligned, the payload is
// de-inverted and header errors are reported and counted.
//
// Ports:
//   USER_CLK        clock, rising edge
//   SYSTEM_RESET_N  asynchronous active-low reset
//   DATA_IN         receive word, bit 0 received first
//   DATA_VALID      DATA_IN qualifier; the gearbox only advances when high
//   PASSTHROUGH     forces SYNCING, suppresses slips, disables de-inversion
//   ERR_CNT_CLR     synchronous clear of ERR_COUNT
//   DATA_OUT        decoded 64-bit payload
//   HEADER_OUT      2-bit sync header of the block
//   DATA_VALID_OUT  one-cycle strobe per emitted block
//   HEADER_ERR      strobe alongside DATA_VALID_OUT when the header is invalid
//   LOCKED          high while the block-lock FSM is in LOCKED
//   ERR_COUNT       saturating count of invalid headers seen while LOCKED
// ---------------------------------------------------------------------------
module decode_64b67b_gearbox_sync #(
  parameter int DATA_W        = 64,
  parameter int GOOD_SYNC_CNT = 64,
  parameter int ERR_SYNC_CNT  = 16,
  parameter int ERR_CNT_W     = 16
) (
  input  logic                 USER_CLK,
  input  logic                 SYSTEM_RESET_N,
  input  logic [DATA_W-1:0]    DATA_IN,
  input  logic                 DATA_VALID,
  input  logic                 PASSTHROUGH,
  input  logic                 ERR_CNT_CLR,
  output logic [63:0]          DATA_OUT,
  output logic [1:0]           HEADER_OUT,
  output logic                 DATA_VALID_OUT,
  output logic                 HEADER_ERR,
  output logic                 LOCKED,
  output logic [ERR_CNT_W-1:0] ERR_COUNT
);

  localparam int BLK_W  = 67;
  localparam int BUF_W  = 66;
  localparam int CMB_W  = BUF_W + DATA_W;
  localparam int FILL_W = 7;
  localparam int CTR_W  = 8;

  // Reject parameter sets the datapath and counters are not sized for.
  if (DATA_W < 32 || DATA_W > 67) begin : g_bad_data_w
    $error("decode_64b67b_gearbox_sync: DATA_W must be 32..67");
  end
  if (GOOD_SYNC_CNT < 2 || GOOD_SYNC_CNT > 255) begin : g_bad_good
    $error("decode_64b67b_gearbox_sync: GOOD_SYNC_CNT must be 2..255");
  end
  if (ERR_SYNC_CNT < 1 || ERR_SYNC_CNT > GOOD_SYNC_CNT) begin : g_bad_err
    $error("decode_64b67b_gearbox_sync: ERR_SYNC_CNT must be 1..GOOD_SYNC_CNT");
  end

  typedef enum logic {
    ST_SYNCING = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 slip_q, slip_d;
  logic [CTR_W-1:0]     good_q, good_d;
  logic [CTR_W-1:0]     win_q, win_d;
  logic [CTR_W-1:0]     err_q, err_d;
  logic [63:0]          data_q;
  logic [1:0]           hdr_q;
  logic                 dv_q, herr_q;
  logic [ERR_CNT_W-1:0] errcnt_q;

  logic [BUF_W-1:0]     fillMask;
  logic [CMB_W-1:0]     combined, shifted;
  logic [CTR_W-1:0]     avail;
  logic                 doSlip, blkAvail, hdrBad;
  logic [BLK_W-1:0]     block;
  logic [CTR_W-1:0]     goodInc, winInc, errInc;

  // Gearbox: new word is appended above the buffered bits; an optional slip
  // drops the oldest bit. Bits above fill are masked so stale data can never
  // leak into a block.
  always_comb begin
    fillMask = (BUF_W'(1) << fill_q) - BUF_W'(1);
    combined = CMB_W'(buf_q & fillMask) | (CMB_W'(DATA_IN) << fill_q);
    doSlip   = slip_q & ~PASSTHROUGH;
    shifted  = doSlip ? (combined >> 1) : combined;
    avail    = {1'b0, fill_q} + CTR_W'(DATA_W) - CTR_W'(doSlip);
    blkAvail = DATA_VALID & (avail >= CTR_W'(BLK_W));
    block    = shifted[BLK_W-1:0];
    hdrBad   = (block[65] == block[64]);
    buf_d    = buf_q;
    fill_d   = fill_q;
    if (DATA_VALID) begin
      if (blkAvail) begin
        buf_d  = BUF_W'(shifted >> BLK_W);
        fill_d = FILL_W'(avail - CTR_W'(BLK_W));
      end else begin
        buf_d  = BUF_W'(shifted);
        fill_d = FILL_W'(avail);
      end
    end
  end

  // Block-lock FSM; it only reacts to extracted blocks, except PASSTHROUGH
  // which holds it in SYNCING unconditionally.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    err_d   = err_q;
    slip_d  = slip_q;
    goodInc = good_q + CTR_W'(1);
    winInc  = win_q + CTR_W'(1);
    errInc  = err_q + CTR_W'(hdrBad);
    if (DATA_VALID && doSlip) begin
      slip_d = 1'b0;
    end
    if (PASSTHROUGH) begin
      state_d = ST_SYNCING;
      good_d  = '0;
      win_d   = '0;
      err_d   = '0;
      slip_d  = 1'b0;
    end else if (blkAvail) begin
      case (state_q)
        ST_SYNCING: begin
          if (hdrBad) begin
            good_d = '0;
            slip_d = 1'b1;
          end else if (goodInc == CTR_W'(GOOD_SYNC_CNT)) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            win_d   = '0;
            err_d   = '0;
          end else begin
            good_d = goodInc;
          end
        end
        ST_LOCKED: begin
          // Losing lock takes priority over closing the monitoring window.
          if (errInc == CTR_W'(ERR_SYNC_CNT)) begin
            state_d = ST_SYNCING;
            good_d  = '0;
            win_d   = '0;
            err_d   = '0;
          end else if (winInc == CTR_W'(GOOD_SYNC_CNT)) begin
            win_d = '0;
            err_d = '0;
          end else begin
            win_d = winInc;
            err_d = errInc;
          end
        end
        default: state_d = ST_SYNCING;
      endcase
    end
  end

  // State, gearbox and counter registers.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state_q <= ST_SYNCING;
      buf_q   <= '0;
      fill_q  <= '0;
      slip_q  <= 1'b0;
      good_q  <= '0;
      win_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      slip_q  <= slip_d;
      good_q  <= good_d;
      win_q   <= win_d;
      err_q   <= err_d;
    end
  end

  // Registered output stage; payload and header hold between strobes.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      data_q   <= '0;
      hdr_q    <= '0;
      dv_q     <= 1'b0;
      herr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      dv_q   <= blkAvail;
      herr_q <= blkAvail & hdrBad;
      if (blkAvail) begin
        data_q <= block[63:0] ^ {64{block[66] & ~PASSTHROUGH}};
        hdr_q  <= block[65:64];
      end
      // Clear wins over a simultaneous increment; the count saturates.
      if (ERR_CNT_CLR) begin
        errcnt_q <= '0;
      end else if (blkAvail && hdrBad && state_q == ST_LOCKED && errcnt_q != '1) begin
        errcnt_q <= errcnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign DATA_OUT       = data_q;
  assign HEADER_OUT     = hdr_q;
  assign DATA_VALID_OUT = dv_q;
  assign HEADER_ERR     = herr_q;
  assign LOCKED         = (state_q == ST_LOCKED);
  assign ERR_COUNT      = errcnt_q;

endmodule

// File: tb/tb_decode_64b67b_gearbox_sync.sv
// ---------------------------------------------------------------------------
// tb_decode_64b67b_gearbox_sync
//
// Randomised bench for decode_64b67b_gearbox_sync. A transmit bit queue is
// filled with 67-bit blocks (LSB first) and cut into receive words. A
// reference model operating on a plain bit queue predicts each emitted
// block; predictions go into a scoreboard queue that a separate monitor
// drains whenever DATA_VALID_OUT strobes.
// ---------------------------------------------------------------------------
module tb_decode_64b67b_gearbox_sync;

  localparam int DATA_W  = 64;
  localparam int GOOD    = 64;
  localparam int ERRS    = 16;
  localparam int ECW     = 5;
  localparam int ECMAX   = (1 << ECW) - 1;

  logic              clk = 1'b0;
  logic              rstN;
  logic [DATA_W-1:0] dataIn;
  logic              dataValid, passthrough, errClr;
  logic [63:0]       dataOut;
  logic [1:0]        headerOut;
  logic              dataValidOut, headerErr, locked;
  logic [ECW-1:0]    errCount;

  decode_64b67b_gearbox_sync #(
    .DATA_W(DATA_W), .GOOD_SYNC_CNT(GOOD), .ERR_SYNC_CNT(ERRS), .ERR_CNT_W(ECW)
  ) dut (
    .USER_CLK(clk), .SYSTEM_RESET_N(rstN), .DATA_IN(dataIn), .DATA_VALID(dataValid),
    .PASSTHROUGH(passthrough), .ERR_CNT_CLR(errClr), .DATA_OUT(dataOut),
    .HEADER_OUT(headerOut), .DATA_VALID_OUT(dataValidOut), .HEADER_ERR(headerErr),
    .LOCKED(locked), .ERR_COUNT(errCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]    data;
    logic [1:0]     hdr;
    logic           herr;
    logic           lck;
    logic [ECW-1:0] ecnt;
  } exp_t;

  exp_t expQ[$];
  bit   txQ[$];
  bit   rxQ[$];
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;

  // Reference model state
  bit mSlip, mLocked;
  int mGood, mWin, mErr, mErrCount;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    rxQ.delete();
    mSlip = 0; mLocked = 0;
    mGood = 0; mWin = 0; mErr = 0; mErrCount = 0;
  endtask

  // One receive cycle of the reference model.
  task automatic modelStep(input bit valid, input logic [DATA_W-1:0] word, input bit pt, input bit clr);
    bit [66:0] blk;
    bit got, bad;
    exp_t e;
    blk = '0;
    got = 0;
    if (valid) begin
      for (int i = 0; i < DATA_W; i++) rxQ.push_back(word[i]);
      if (mSlip && !pt) void'(rxQ.pop_front());
      mSlip = 0;
      if (rxQ.size() >= 67) begin
        for (int i = 0; i < 67; i++) blk[i] = rxQ.pop_front();
        got = 1;
      end
    end
    bad = (blk[65] == blk[64]);
    if (got && bad && mLocked && mErrCount < ECMAX) mErrCount++;
    if (clr) mErrCount = 0;
    if (pt) begin
      mLocked = 0; mGood = 0; mWin = 0; mErr = 0; mSlip = 0;
    end else if (got) begin
      if (!mLocked) begin
        if (bad) begin
          mGood = 0; mSlip = 1;
        end else begin
          mGood++;
          if (mGood == GOOD) begin
            mLocked = 1; mGood = 0; mWin = 0; mErr = 0;
          end
        end
      end else begin
        mWin++;
        if (bad) mErr++;
        if (mErr == ERRS) begin
          mLocked = 0; mGood = 0; mWin = 0; mErr = 0;
        end else if (mWin == GOOD) begin
          mWin = 0; mErr = 0;
        end
      end
    end
    if (got) begin
      e.data = blk[63:0] ^ ((blk[66] && !pt) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
      e.hdr  = blk[65:64];
      e.herr = bad;
      e.lck  = mLocked;
      e.ecnt = ECW'(mErrCount);
      expQ.push_back(e);
    end
  endtask

  task automatic pushBlock(input bit inv, input logic [1:0] hdr, input logic [63:0] payload);
    logic [66:0] b;
    b = {inv, hdr, payload};
    for (int i = 0; i < 67; i++) txQ.push_back(b[i]);
  endtask

  task automatic pushGood(input int n);
    for (int i = 0; i < n; i++)
      pushBlock(1'($urandom), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, {$urandom, $urandom});
  endtask

  task automatic pushBad();
    pushBlock(1'($urandom), ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11, {$urandom, $urandom});
  endtask

  task automatic pushJunk(input int n);
    for (int i = 0; i < n; i++) txQ.push_back(1'($urandom_range(0, 1)));
  endtask

  // Drives one cycle; invalid cycles carry random garbage on DATA_IN.
  task automatic applyStimulus(input bit wantValid, input bit pt, input bit clr);
    logic [DATA_W-1:0] w;
    bit v;
    v = wantValid && (txQ.size() >= DATA_W);
    w = DATA_W'({$urandom, $urandom, $urandom});
    if (v) for (int i = 0; i < DATA_W; i++) w[i] = txQ.pop_front();
    dataIn = w; dataValid = v; passthrough = pt; errClr = clr;
    modelStep(v, w, pt, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int pctValid, input bit pt);
    int budget;
    budget = 4000;
    while (txQ.size() >= DATA_W && budget > 0) begin
      applyStimulus($urandom_range(1, 100) <= pctValid, pt, 1'b0);
      budget--;
    end
    checkOutput("drain_budget", 64'(budget > 0), 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, pt, 1'b0);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    #1;
    dataValid = 0; passthrough = 0; errClr = 0;
    rstN = 0;
    #1;
    checkOutput("rst_data_out", dataOut, 64'h0);
    checkOutput("rst_header_out", 64'(headerOut), 64'h0);
    checkOutput("rst_valid_out", 64'(dataValidOut), 64'h0);
    checkOutput("rst_header_err", 64'(headerErr), 64'h0);
    checkOutput("rst_locked", 64'(locked), 64'h0);
    checkOutput("rst_err_count", 64'(errCount), 64'h0);
    checkOutput("rst_sb_empty", 64'(expQ.size()), 64'h0);
    modelReset();
    txQ.delete();
    expQ.delete();
    strobes = 0;
    @(posedge clk);
    #1;
    rstN = 1;
  endtask

  // Monitor: every output strobe must match the oldest prediction.
  always @(negedge clk) begin
    if (rstN === 1'b1 && dataValidOut === 1'b1) begin
      strobes++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got strobe expected none at %0t", $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("data_out", dataOut, e.data);
        checkOutput("header_out", 64'(headerOut), 64'(e.hdr));
        checkOutput("header_err", 64'(headerErr), 64'(e.herr));
        checkOutput("locked", 64'(locked), 64'(e.lck));
        checkOutput("err_count", 64'(errCount), 64'(e.ecnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit isBad[64];
    int nBad, p;
    rstN = 1; dataIn = '0; dataValid = 0; passthrough = 0; errClr = 0;
    modelReset();
    #2;
    resetPulse();

    // Aligned stream: 67 words = 64 blocks, lock on the 64th strobe.
    pushGood(64);
    drain(100, 0);
    checkOutput("aligned_locked", 64'(locked), 64'd1);
    checkOutput("aligned_strobes", 64'(strobes), 64'd64);

    // 15 bad headers inside one window: lock holds.
    foreach (isBad[i]) isBad[i] = 0;
    nBad = 0;
    while (nBad < 15) begin
      p = $urandom_range(0, 63);
      if (!isBad[p]) begin isBad[p] = 1; nBad++; end
    end
    for (int i = 0; i < 64; i++) if (isBad[i]) pushBad(); else pushGood(1);
    drain(100, 0);
    checkOutput("err15_locked", 64'(locked), 64'd1);
    checkOutput("err15_count", 64'(errCount), 64'd15);

    // 16 bad headers, all in the first 50 blocks: lock is lost.
    foreach (isBad[i]) isBad[i] = 0;
    nBad = 0;
    while (nBad < 16) begin
      p = $urandom_range(0, 49);
      if (!isBad[p]) begin isBad[p] = 1; nBad++; end
    end
    for (int i = 0; i < 64; i++) if (isBad[i]) pushBad(); else pushGood(1);
    drain(100, 0);
    checkOutput("err16_locked", 64'(locked), 64'd0);
    checkOutput("err16_count", 64'(errCount), 64'd31);

    // 5-bit offset: gearbox slips back into alignment and relocks.
    pushJunk(5);
    pushGood(120);
    drain(100, 0);
    checkOutput("offset_relocked", 64'(locked), 64'd1);

    // Inverted payload plus a few bad headers against a saturated counter.
    pushBlock(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
    pushGood(2); pushBad(); pushGood(2); pushBad(); pushBad(); pushGood(4);
    drain(100, 0);
    checkOutput("sat_err_count", 64'(errCount), 64'(ECMAX));
    checkOutput("sat_locked", 64'(locked), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_err_count", 64'(errCount), 64'h0);

    // Passthrough: raw payloads, lock forced off.
    pushBlock(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
    pushGood(20);
    drain(100, 1);
    checkOutput("pt_locked", 64'(locked), 64'd0);

    // Relock with DATA_VALID toggling about half the time.
    pushGood(140);
    drain(50, 0);
    checkOutput("gapped_locked", 64'(locked), 64'd1);

    // Reset mid-block with 40 bits buffered, then fresh relock.
    resetPulse();
    pushGood(70);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    resetPulse();
    pushGood(64);
    drain(100, 0);
    checkOutput("post_rst_locked", 64'(locked), 64'd1);
    checkOutput("post_rst_strobes", 64'(strobes), 64'd64);
    checkOutput("post_rst_err_count", 64'(errCount), 64'h0);

    checkOutput("sb_drained", 64'(expQ.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_64b67b_gearbox_sync.md
Name: decode_64b67b_gearbox_sync

Overview:
Parametrised successor to the fixed 80-bit 64B/67B decoder. A bit-accurate gearbox accumulates DATA_W-bit receive words and extracts 67-bit Interlaken blocks. A block-lock FSM with configurable thresholds slips the gearbox one bit at a time until alignment is found. The block then de-inverts the payload and reports header errors. It sits between the transceiver RX interface and the descrambler / lane framer.

Parameters:
DATA_W, 64, receive word width. Legal range 32..67; elaboration error outside this range.
GOOD_SYNC_CNT, 64, consecutive good headers needed to lock. Also the LOCKED-state monitoring window length. Range 2..255.
ERR_SYNC_CNT, 16, bad headers within one window that cause loss of lock. Range 1..GOOD_SYNC_CNT.
ERR_CNT_W, 16, width of the saturating header-error counter.

Ports:
USER_CLK  in  1  clock, rising edge.
SYSTEM_RESET_N  in  1  asynchronous assert, active-low reset.
DATA_IN  in  DATA_W  receive word; bit 0 is received first.
DATA_VALID  in  1  DATA_IN qualifier; the gearbox advances only when this is high.
PASSTHROUGH  in  1  holds the FSM in SYNCING, suppresses slips, disables de-inversion.
ERR_CNT_CLR  in  1  synchronous clear of ERR_COUNT.
DATA_OUT  out  64  decoded payload.
HEADER_OUT  out  2  block sync header, bits [65:64].
DATA_VALID_OUT  out  1  one-cycle strobe per emitted block.
HEADER_ERR  out  1  strobe with DATA_VALID_OUT when the header is invalid.
LOCKED  out  1  high in LOCKED state.
ERR_COUNT  out  ERR_CNT_W  saturating count of invalid headers seen while LOCKED.

Behaviour:
- Reset (async, SYSTEM_RESET_N=0): all outputs 0; gearbox fill=0; slip_pending=0; FSM=SYNCING; all counters 0.
- Gearbox, each cycle with DATA_VALID=1:
  - combined = {DATA_IN, buf[fill-1:0]}.
  - If slip_pending: drop combined bit 0 first, avail = fill+DATA_W-1, clear slip_pending. Otherwise avail = fill+DATA_W.
  - If avail>=67: block = lowest 67 bits; fill' = avail-67; remaining bits kept in order. Otherwise no block; fill' = avail.
  - Buffer width 66 bits; fill never exceeds 66.
- DATA_VALID=0: gearbox, FSM and counters frozen; DATA_VALID_OUT=0. Lock is not lost.
- Block fields: [66] inversion, [65:64] header, [63:0] payload. Header valid iff [65]!=[64].
- Output stage, registered, one cycle after extraction:
  - DATA_OUT = payload XOR {64{[66] & ~PASSTHROUGH}}.
  - HEADER_OUT = [65:64]; DATA_VALID_OUT=1; HEADER_ERR = ~valid.
  - Outputs hold their values between strobes.
  - Blocks are emitted in every state; downstream qualifies them with LOCKED.
- FSM acts only on extracted blocks.
  - SYNCING:
    - Valid header: good_ctr+1. When good_ctr reaches GOOD_SYNC_CNT -> LOCKED, with good_ctr=0 and err_ctr=0. LOCKED rises with the strobe of the GOOD_SYNC_CNT-th good block.
    - Invalid header: good_ctr=0 and slip_pending=1, so the next cycle drops one bit.
  - LOCKED:
    - Every block increments win_ctr; invalid blocks also increment err_ctr.
    - err_ctr reaching ERR_SYNC_CNT -> SYNCING. This has priority over window end. All counters clear; no slip on that block.
    - Otherwise, when win_ctr reaches GOOD_SYNC_CNT: win_ctr=0, err_ctr=0.
- PASSTHROUGH=1: FSM forced to SYNCING with counters 0 and slip_pending=0. The gearbox keeps running without slips; blocks are still emitted raw.
- ERR_COUNT increments on HEADER_ERR while LOCKED and saturates at all-ones. ERR_CNT_CLR clears it and wins over a simultaneous increment.
- Mid-stream reset discards buffered bits; the next block starts at the first post-reset DATA_IN bit 0.

Test Plan:
1. DATA_W=64, aligned stream of 67 words = 64 blocks, headers 2'b01, bit66=0 -> exactly 64 DATA_VALID_OUT strobes, payloads match, LOCKED rises on the 64th strobe.
2. Same stream offset by 5 bits -> exactly 5 HEADER_ERR events cause 5 slips, then 64 good blocks -> LOCKED=1, after which payloads are bit-exact.
3. Locked; inject 15 bad headers in one 64-block window -> stays LOCKED, ERR_COUNT=15. Inject 16 -> LOCKED falls after the 16th bad strobe.
4. Block with bit66=1, payload 64'h0123_4567_89AB_CDEF -> DATA_OUT=64'hFEDC_BA98_7654_3210. Same block with PASSTHROUGH=1 -> raw payload, LOCKED=0.
5. DATA_VALID toggled 50% while locked -> no lock loss, block sequence identical to the continuous run.
6. SYSTEM_RESET_N pulsed low mid-block with fill=40 -> outputs 0 immediately (async); relock requires 64 fresh good blocks; ERR_COUNT=0.
